// File: rtl/jvo_pulse_pkg.sv
// jvo_pulse_pkg: shared constants, address map and commit FSM states for the pulse config bank
package jvo_pulse_pkg;
  localparam int          N_CH_DEF        = 20;
  localparam logic [31:0] MAX_CNT_RST_DEF = 32'd124_999_999;
  localparam logic [5:0]  ADDR_BEG        = 6'd0;
  localparam logic [5:0]  ADDR_END        = 6'd32;
  localparam logic [5:0]  ADDR_IO_INIT    = 6'd62;
  localparam logic [5:0]  ADDR_MAX_CNT    = 6'd63;
  typedef enum logic [1:0] {IDLE, PENDING, APPLY} state_e;
endpackage

// File: rtl/jvo_pulse_cfg_bank_if.sv
// jvo_pulse_cfg_bank_if: valid/ready write channel into the shadow register file
interface jvo_pulse_cfg_bank_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  modport master (output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/jvo_cfg_regfile.sv
// jvo_cfg_regfile: shadow register array with address decode and sticky unmapped-address flag
module jvo_cfg_regfile
  import jvo_pulse_pkg::*;
#(
  parameter int          N_CH        = N_CH_DEF,
  parameter logic [31:0] MAX_CNT_RST = MAX_CNT_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] sh_beg [N_CH],
  output logic [31:0] sh_end [N_CH],
  output logic [31:0] sh_io_init,
  output logic [31:0] sh_max_cnt,
  output logic        addr_err
);
  logic [31:0] beg_q [N_CH];
  logic [31:0] beg_d [N_CH];
  logic [31:0] end_q [N_CH];
  logic [31:0] end_d [N_CH];
  logic [31:0] io_init_q, io_init_d;
  logic [31:0] max_cnt_q, max_cnt_d;
  logic        addr_err_q, addr_err_d;
  logic        hit;
  // io_init/max_count take priority should the end range ever reach 62/63
  always_comb begin
    beg_d      = beg_q;
    end_d      = end_q;
    io_init_d  = io_init_q;
    max_cnt_d  = max_cnt_q;
    hit        = 1'b0;
    if (addr == ADDR_IO_INIT) begin
      io_init_d = we ? data : io_init_q;
      hit       = 1'b1;
    end else if (addr == ADDR_MAX_CNT) begin
      max_cnt_d = we ? data : max_cnt_q;
      hit       = 1'b1;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (addr == 6'(int'(ADDR_BEG) + i)) begin
          beg_d[i] = we ? data : beg_q[i];
          hit      = 1'b1;
        end
        if (addr == 6'(int'(ADDR_END) + i)) begin
          end_d[i] = we ? data : end_q[i];
          hit      = 1'b1;
        end
      end
    end
    addr_err_d = addr_err_q | (we & ~hit);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        beg_q[i] <= '0;
        end_q[i] <= '0;
      end
      io_init_q  <= '0;
      max_cnt_q  <= MAX_CNT_RST;
      addr_err_q <= 1'b0;
    end else begin
      beg_q      <= beg_d;
      end_q      <= end_d;
      io_init_q  <= io_init_d;
      max_cnt_q  <= max_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end
  assign sh_beg     = beg_q;
  assign sh_end     = end_q;
  assign sh_io_init = io_init_q;
  assign sh_max_cnt = max_cnt_q;
  assign addr_err   = addr_err_q;
endmodule

// File: rtl/jvo_pulse_cfg_bank.sv
// jvo_pulse_cfg_bank: shadow/active pulse configuration with commit synchronised to the pulse period
module jvo_pulse_cfg_bank
  import jvo_pulse_pkg::*;
#(
  parameter int          N_CH        = N_CH_DEF,
  parameter logic [31:0] MAX_CNT_RST = MAX_CNT_RST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  jvo_pulse_cfg_bank_if.slave  wr,
  input  logic                 commit_req,
  input  logic                 run,
  input  logic                 period_end,
  output logic [31:0]          cnt_beg [N_CH],
  output logic [31:0]          cnt_end [N_CH],
  output logic [31:0]          io_init,
  output logic [31:0]          max_count,
  output logic                 cfg_pending,
  output logic [15:0]          commit_cnt,
  output logic                 addr_err
);
  state_e      state_q, state_d;
  logic        wr_ready_q, cfg_pending_q;
  logic [31:0] sh_beg [N_CH];
  logic [31:0] sh_end [N_CH];
  logic [31:0] sh_io_init, sh_max_cnt;
  logic [31:0] beg_q [N_CH];
  logic [31:0] beg_d [N_CH];
  logic [31:0] end_q [N_CH];
  logic [31:0] end_d [N_CH];
  logic [31:0] io_init_q, io_init_d;
  logic [31:0] max_cnt_q, max_cnt_d;
  logic [15:0] commit_cnt_q, commit_cnt_d;
  logic        apply;
  jvo_cfg_regfile #(.N_CH(N_CH), .MAX_CNT_RST(MAX_CNT_RST)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we         (wr.wr_valid & wr_ready_q),
    .addr       (wr.wr_addr),
    .data       (wr.wr_data),
    .sh_beg     (sh_beg),
    .sh_end     (sh_end),
    .sh_io_init (sh_io_init),
    .sh_max_cnt (sh_max_cnt),
    .addr_err   (addr_err)
  );
  // commit_req outside IDLE is dropped; a running generator defers the copy to a period boundary
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = commit_req ? (run ? PENDING : APPLY) : IDLE;
      PENDING: state_d = (period_end || !run) ? APPLY : PENDING;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_ready_q    <= 1'b1;
      cfg_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ready_q    <= state_d == IDLE;
      cfg_pending_q <= state_d != IDLE;
    end
  end
  assign apply = state_q == APPLY;
  always_comb begin
    beg_d        = beg_q;
    end_d        = end_q;
    io_init_d    = apply ? sh_io_init : io_init_q;
    max_cnt_d    = apply ? sh_max_cnt : max_cnt_q;
    commit_cnt_d = commit_cnt_q + 16'(apply);
    if (apply) begin
      beg_d = sh_beg;
      end_d = sh_end;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        beg_q[i] <= '0;
        end_q[i] <= '0;
      end
      io_init_q    <= '0;
      max_cnt_q    <= MAX_CNT_RST;
      commit_cnt_q <= '0;
    end else begin
      beg_q        <= beg_d;
      end_q        <= end_d;
      io_init_q    <= io_init_d;
      max_cnt_q    <= max_cnt_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end
  assign wr.wr_ready  = wr_ready_q;
  assign cnt_beg      = beg_q;
  assign cnt_end      = end_q;
  assign io_init      = io_init_q;
  assign max_count    = max_cnt_q;
  assign cfg_pending  = cfg_pending_q;
  assign commit_cnt   = commit_cnt_q;
endmodule

// File: tb/tb_jvo_pulse_cfg_bank.sv
// tb_jvo_pulse_cfg_bank: table-driven commit vectors plus hand-written pending/reset/wrap sequences
module tb_jvo_pulse_cfg_bank;
  localparam int N_CH = 20;
  localparam logic [31:0] MAXR = 32'd124_999_999;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_req = 1'b0;
  logic        run = 1'b0;
  logic        period_end = 1'b0;
  logic [31:0] cnt_beg [N_CH];
  logic [31:0] cnt_end [N_CH];
  logic [31:0] io_init, max_count;
  logic        cfg_pending, addr_err;
  logic [15:0] commit_cnt;
  int          checks = 0;
  int          failures = 0;
  jvo_pulse_cfg_bank_if wr_if ();
  jvo_pulse_cfg_bank #(.N_CH(N_CH), .MAX_CNT_RST(MAXR)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr_if),
    .commit_req  (commit_req),
    .run         (run),
    .period_end  (period_end),
    .cnt_beg     (cnt_beg),
    .cnt_end     (cnt_end),
    .io_init     (io_init),
    .max_count   (max_count),
    .cfg_pending (cfg_pending),
    .commit_cnt  (commit_cnt),
    .addr_err    (addr_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        same;
    int          kind;
    int          idx;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;
  vec_t vecs [9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] act_of(input int kind, input int idx);
    return kind == 0 ? cnt_beg[idx] : kind == 1 ? cnt_end[idx] : kind == 2 ? io_init : max_count;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_data  = d;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask
  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_data  = '0;
    vecs[0] = '{6'd0,  32'd5,      1'b0, 0, 0,  32'd5,      1'b0};
    vecs[1] = '{6'd32, 32'd10,     1'b0, 1, 0,  32'd10,     1'b0};
    vecs[2] = '{6'd19, 32'hABCD,   1'b0, 0, 19, 32'hABCD,   1'b0};
    vecs[3] = '{6'd51, 32'h1234,   1'b0, 1, 19, 32'h1234,   1'b0};
    vecs[4] = '{6'd62, 32'hF,      1'b1, 2, 0,  32'hF,      1'b0};
    vecs[5] = '{6'd63, 32'd99,     1'b0, 3, 0,  32'd99,     1'b0};
    vecs[6] = '{6'd25, 32'hDEAD,   1'b0, 0, 0,  32'd5,      1'b1};
    vecs[7] = '{6'd52, 32'hBEEF,   1'b0, 1, 19, 32'h1234,   1'b1};
    vecs[8] = '{6'd0,  32'd6,      1'b1, 0, 0,  32'd6,      1'b1};
    do_reset();
    chk("rst_wr_ready", wr_if.wr_ready, 1);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_err", addr_err, 0);
    chk("rst_max", max_count, MAXR);
    chk("rst_beg0", cnt_beg[0], 0);
    chk("rst_io", io_init, 0);
    wr(6'd1, 32'd77);
    tick();
    chk("shadow_only_beg1", cnt_beg[1], 0);
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].same) begin
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = vecs[i].addr;
        wr_if.wr_data  = vecs[i].data;
        commit_req     = 1'b1;
        tick();
        wr_if.wr_valid = 1'b0;
        commit_req     = 1'b0;
      end else begin
        wr(vecs[i].addr, vecs[i].data);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
      end
      chk($sformatf("v%0d_pending", i), cfg_pending, 1);
      tick();
      chk($sformatf("v%0d_val", i), act_of(vecs[i].kind, vecs[i].idx), vecs[i].exp);
      chk($sformatf("v%0d_err", i), addr_err, vecs[i].exp_err);
      chk($sformatf("v%0d_cnt", i), commit_cnt, 16'(i + 1));
    end
    chk("beg1_committed", cnt_beg[1], 77);
    do_reset();
    chk("rst2_beg0", cnt_beg[0], 0);
    chk("rst2_max", max_count, MAXR);
    chk("rst2_err", addr_err, 0);
    run = 1'b1;
    wr(6'd63, 32'd99);
    commit_req = 1'b1;
    period_end = 1'b1;
    tick();
    commit_req = 1'b0;
    period_end = 1'b0;
    chk("pend_flag", cfg_pending, 1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("pend%0d_ready", k), wr_if.wr_ready, 0);
      chk($sformatf("pend%0d_max", k), max_count, MAXR);
      commit_req = (k == 2);
      tick();
    end
    commit_req = 1'b0;
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
    chk("apply_max_old", max_count, MAXR);
    chk("apply_ready", wr_if.wr_ready, 0);
    chk("apply_pending", cfg_pending, 1);
    tick();
    chk("run_max_new", max_count, 99);
    chk("run_cnt", commit_cnt, 1);
    chk("run_pending", cfg_pending, 0);
    chk("run_ready", wr_if.wr_ready, 1);
    wr(6'd0, 32'd3);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    run = 1'b0;
    tick();
    tick();
    chk("rundrop_beg0", cnt_beg[0], 3);
    chk("rundrop_cnt", commit_cnt, 2);
    run = 1'b1;
    wr(6'd62, 32'd5);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    chk("abandon_pending_pre", cfg_pending, 1);
    rst = 1'b1;
    #2;
    chk("async_pending", cfg_pending, 0);
    chk("async_ready", wr_if.wr_ready, 1);
    run = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("abandon_io", io_init, 0);
    chk("abandon_max", max_count, MAXR);
    chk("abandon_beg0", cnt_beg[0], 0);
    chk("abandon_cnt", commit_cnt, 0);
    chk("abandon_pending", cfg_pending, 0);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    chk("abandon_shadow_io", io_init, 0);
    chk("abandon_commit_cnt", commit_cnt, 1);
    force dut.commit_cnt_q = 16'hFFFF;
    tick();
    tick();
    release dut.commit_cnt_q;
    chk("wrap_pre", commit_cnt, 16'hFFFF);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    chk("wrap_post", commit_cnt, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
